// File: rtl/avalon_reg_bank_slave_pkg.sv
// Shared register map, STATUS layout and the byte-lane merge helper for the Avalon register bank.
package avalon_reg_bank_slave_pkg;

  localparam logic [1:0]  ADDR_REG0      = 2'd0;
  localparam logic [1:0]  ADDR_REG1      = 2'd1;
  localparam logic [1:0]  ADDR_REG2      = 2'd2;
  localparam logic [1:0]  ADDR_STATUS    = 2'd3;
  localparam int          STATUS_ERR_BIT = 31;
  localparam logic [30:0] WCOUNT_MAX     = 31'h7FFF_FFFF;

  typedef struct packed {
    logic        err;
    logic [30:0] wcount;
  } status_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_q,
                                             input logic [31:0] new_d,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_q;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) res[8*k +: 8] = new_d[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/avalon_reg_bank_slave_if.sv
// Avalon-MM bus bundle between the read-increment-write master and the register bank slave.
interface avalon_reg_bank_slave_if;

  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, read, write, byteenable, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/avalon_reg_bank_slave_rd_pipe.sv
// Fixed-latency read return pipe: LATENCY cycles from in_vld to out_vld, no backpressure (always accepts).
// Synchronous flush drops every in-flight read; out_dat is forced to zero whenever out_vld is low.
module avalon_reg_bank_slave_rd_pipe #(
  parameter int LATENCY = 2,
  parameter int W       = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  output logic [W-1:0] out_dat
);

  logic [LATENCY-1:0] vld_sr;
  logic [W-1:0]       dat_sr [LATENCY];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_sr <= '0;
      for (int i = 0; i < LATENCY; i++) dat_sr[i] <= '0;
    end else begin
      vld_sr[0] <= in_vld;
      dat_sr[0] <= in_vld ? in_dat : '0;
      for (int i = 1; i < LATENCY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        dat_sr[i] <= dat_sr[i-1];
      end
    end
  end

  assign out_vld = vld_sr[LATENCY-1];
  assign out_dat = vld_sr[LATENCY-1] ? dat_sr[LATENCY-1] : '0;

endmodule

// File: rtl/avalon_reg_bank_slave.sv
// Avalon-MM slave: 3 RW regs + STATUS; WAIT_STATES stall cycles per request, reads return after READ_LATENCY.
// Backpressure via combinational waitrequest; accepted reads stream back-to-back through the read pipe.
module avalon_reg_bank_slave
  import avalon_reg_bank_slave_pkg::*;
#(
  parameter int WAIT_STATES  = 1,
  parameter int READ_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  avalon_reg_bank_slave_if.slave    bus,
  output logic [31:0]               reg0_q
);

  localparam logic [2:0] WS_LAST = 3'(WAIT_STATES);

  logic [2:0]  ws_cnt;
  logic        req;
  logic        stall;
  logic        accept;
  logic        wr_acc;
  logic        rd_acc;
  logic [31:0] reg0;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic        status_err;
  logic [30:0] status_wcount;
  status_t     status_rd;
  logic [31:0] rd_mux;

  assign req     = bus.read | bus.write;
  assign stall   = req & (ws_cnt != WS_LAST);
  assign accept  = req & ~stall;
  // read+write together is a protocol error and is serviced as a write only
  assign wr_acc  = accept & bus.write;
  assign rd_acc  = accept & bus.read & ~bus.write;

  assign bus.waitrequest = stall;
  assign reg0_q          = reg0;

  always_ff @(posedge clk) begin
    if (reset || accept || !req) ws_cnt <= 3'd0;
    else                         ws_cnt <= ws_cnt + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg0          <= '0;
      reg1          <= '0;
      reg2          <= '0;
      status_err    <= 1'b0;
      status_wcount <= '0;
    end else if (wr_acc) begin
      case (bus.address)
        ADDR_REG0: reg0 <= byte_merge(reg0, bus.writedata, bus.byteenable);
        ADDR_REG1: reg1 <= byte_merge(reg1, bus.writedata, bus.byteenable);
        ADDR_REG2: reg2 <= byte_merge(reg2, bus.writedata, bus.byteenable);
        default: begin
          if (bus.byteenable[3] && bus.writedata[STATUS_ERR_BIT]) status_err <= 1'b0;
        end
      endcase
      if (bus.address != ADDR_STATUS && status_wcount != WCOUNT_MAX)
        status_wcount <= status_wcount + 31'd1;
      // placed after the clear so a simultaneous protocol error keeps ERR set
      if (bus.read) status_err <= 1'b1;
    end
  end

  always_comb begin
    status_rd.err    = status_err;
    status_rd.wcount = status_wcount;
    case (bus.address)
      ADDR_REG0: rd_mux = reg0;
      ADDR_REG1: rd_mux = reg1;
      ADDR_REG2: rd_mux = reg2;
      default:   rd_mux = status_rd;
    endcase
  end

  avalon_reg_bank_slave_rd_pipe #(
    .LATENCY (READ_LATENCY),
    .W       (32)
  ) u_rd_pipe (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (rd_acc),
    .in_dat  (rd_mux),
    .out_vld (bus.readdatavalid),
    .out_dat (bus.readdata)
  );

endmodule

// File: tb/tb_avalon_reg_bank_slave.sv
// Bench for avalon_reg_bank_slave: WS=1/RL=2 instance for most features, WS=0/RL=2 instance for streaming.
module tb_avalon_reg_bank_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst0;
  logic [31:0] reg0_q;
  logic [31:0] reg0_q0;

  avalon_reg_bank_slave_if bus ();
  avalon_reg_bank_slave_if bus0 ();

  avalon_reg_bank_slave #(.WAIT_STATES(1), .READ_LATENCY(2)) dut (
    .clk(clk), .reset(rst), .bus(bus), .reg0_q(reg0_q));

  avalon_reg_bank_slave #(.WAIT_STATES(0), .READ_LATENCY(2)) dut0 (
    .clk(clk), .reset(rst0), .bus(bus0), .reg0_q(reg0_q0));

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model of the WS=1 instance and data model of the WS=0 instance
  logic [31:0] mreg [3];
  logic        merr;
  logic [30:0] mwcnt;
  logic [31:0] m0reg [3];

  function automatic logic [31:0] lane_update(input logic [31:0] o, input logic [31:0] d,
                                              input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (o & ~mask) | (d & mask);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) mreg[i] = 32'h0;
    merr  = 1'b0;
    mwcnt = 31'h0;
  endtask

  task automatic model_write(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d,
                             input logic proto);
    if (a != 2'd3) begin
      mreg[a] = lane_update(mreg[a], d, be);
      if (mwcnt != 31'h7FFF_FFFF) mwcnt = mwcnt + 31'd1;
    end else if (be[3] && d[31]) begin
      merr = 1'b0;
    end
    if (proto) merr = 1'b1;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    if (a == 2'd3) return {merr, mwcnt};
    return mreg[a];
  endfunction

  task automatic idle();
    bus.read = 1'b0; bus.write = 1'b0; bus.address = 2'd0;
    bus.byteenable = 4'h0; bus.writedata = 32'h0;
  endtask

  task automatic idle0();
    bus0.read = 1'b0; bus0.write = 1'b0; bus0.address = 2'd0;
    bus0.byteenable = 4'h0; bus0.writedata = 32'h0;
  endtask

  // Called just after a rising edge; returns just after the accepting edge with the request dropped.
  task automatic do_req(input logic rd, input logic wr, input logic [1:0] a, input logic [3:0] be,
                        input logic [31:0] d, output int stalls);
    bus.read = rd; bus.write = wr; bus.address = a; bus.byteenable = be; bus.writedata = d;
    stalls = 0;
    #1;
    while (bus.waitrequest && stalls < 20) begin
      stalls++;
      @(posedge clk); #1;
    end
    if (bus.waitrequest) begin
      checks++; failures++;
      $display("FAIL accept_timeout got=stalled exp=accept within 20 cycles");
    end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d,
                           input logic proto, output int stalls);
    do_req(proto, 1'b1, a, be, d, stalls);
    model_write(a, be, d, proto);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] data, output int lat,
                          output logic pulse_ok);
    int st;
    do_req(1'b1, 1'b0, a, 4'h0, 32'h0, st);
    lat = 1;
    while (!bus.readdatavalid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    data = bus.readdata;
    @(posedge clk); #1;
    pulse_ok = !bus.readdatavalid && (bus.readdata == 32'h0);
  endtask

  task automatic test_reset();
    logic [31:0] d; int lat; logic p;
    rst = 1'b1; rst0 = 1'b1; idle(); idle0(); model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.waitrequest !== 1'b0) begin failures++; $display("FAIL rst_waitrequest got=%b exp=0", bus.waitrequest); end
    checks++; if (bus.readdatavalid !== 1'b0) begin failures++; $display("FAIL rst_rdvalid got=%b exp=0", bus.readdatavalid); end
    checks++; if (bus.readdata !== 32'h0) begin failures++; $display("FAIL rst_readdata got=%h exp=0", bus.readdata); end
    checks++; if (reg0_q !== 32'h0) begin failures++; $display("FAIL rst_reg0_q got=%h exp=0", reg0_q); end
    rst = 1'b0; rst0 = 1'b0;
    @(posedge clk); #1;
    bus_read(2'd3, d, lat, p);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_status got=%h exp=0", d); end
  endtask

  task automatic test_write_read();
    int st, lat; logic [31:0] d; logic p;
    bus_write(2'd0, 4'hF, 32'h0000_0005, 1'b0, st);
    checks++; if (st != 1) begin failures++; $display("FAIL wr_stalls got=%0d exp=1", st); end
    checks++; if (reg0_q !== 32'h5) begin failures++; $display("FAIL wr_reg0_q got=%h exp=5", reg0_q); end
    bus_read(2'd0, d, lat, p);
    checks++; if (lat != 2) begin failures++; $display("FAIL rd_latency got=%0d exp=2", lat); end
    checks++; if (d !== 32'h5) begin failures++; $display("FAIL rd_data got=%h exp=5", d); end
    checks++; if (p !== 1'b1) begin failures++; $display("FAIL rd_pulse got=%b exp=1", p); end
  endtask

  task automatic test_rmw();
    int st, lat; logic [31:0] d; logic p;
    bus_read(2'd0, d, lat, p);
    bus_write(2'd0, 4'hF, d + 32'd1, 1'b0, st);
    checks++; if (reg0_q !== 32'h6) begin failures++; $display("FAIL rmw_reg0_q got=%h exp=6", reg0_q); end
    bus_read(2'd3, d, lat, p);
    checks++; if (d !== 32'h0000_0002) begin failures++; $display("FAIL rmw_status got=%h exp=2", d); end
  endtask

  task automatic test_byte_lanes();
    int st, lat; logic [31:0] d; logic p;
    bus_write(2'd1, 4'hF, 32'hAABB_CCDD, 1'b0, st);
    bus_write(2'd1, 4'b0101, 32'h1122_3344, 1'b0, st);
    bus_read(2'd1, d, lat, p);
    checks++; if (d !== 32'hAA22_CC44) begin failures++; $display("FAIL lanes_data got=%h exp=aa22cc44", d); end
    bus_write(2'd1, 4'b0000, $urandom, 1'b0, st);
    bus_read(2'd1, d, lat, p);
    checks++; if (d !== model_read(2'd1)) begin failures++; $display("FAIL lanes_be0 got=%h exp=%h", d, model_read(2'd1)); end
    bus_read(2'd3, d, lat, p);
    checks++; if (d !== model_read(2'd3)) begin failures++; $display("FAIL lanes_count got=%h exp=%h", d, model_read(2'd3)); end
  endtask

  task automatic test_back_to_back_ws0();
    logic [6:0]  vld;
    logic [31:0] dat [7];
    int nv;
    for (int i = 0; i < 3; i++) begin
      m0reg[i] = $urandom;
      bus0.write = 1'b1; bus0.address = 2'(i); bus0.byteenable = 4'hF; bus0.writedata = m0reg[i];
      #1;
      checks++; if (bus0.waitrequest !== 1'b0) begin failures++; $display("FAIL ws0_wait got=%b exp=0", bus0.waitrequest); end
      @(posedge clk); #1;
    end
    idle0();
    for (int i = 0; i < 7; i++) begin
      if (i < 3) begin bus0.read = 1'b1; bus0.address = 2'(i); end
      else idle0();
      @(posedge clk); #1;
      vld[i] = bus0.readdatavalid;
      dat[i] = bus0.readdata;
    end
    checks++; if (vld !== 7'b0001110) begin failures++; $display("FAIL ws0_vld_pattern got=%b exp=0001110", vld); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (dat[i+1] !== m0reg[i]) begin failures++; $display("FAIL ws0_data%0d got=%h exp=%h", i, dat[i+1], m0reg[i]); end
    end
    // reset lands while reads are in flight
    for (int i = 0; i < 2; i++) begin
      bus0.read = 1'b1; bus0.address = 2'(i);
      @(posedge clk); #1;
    end
    bus0.address = 2'd2;
    rst0 = 1'b1;
    nv = 0;
    @(posedge clk); #1;
    idle0();
    if (bus0.readdatavalid) nv++;
    @(posedge clk); #1;
    rst0 = 1'b0;
    if (bus0.readdatavalid) nv++;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus0.readdatavalid) nv++;
    end
    checks++; if (nv != 0) begin failures++; $display("FAIL ws0_reset_valids got=%0d exp=0", nv); end
    checks++; if (reg0_q0 !== 32'h0) begin failures++; $display("FAIL ws0_reset_reg0 got=%h exp=0", reg0_q0); end
  endtask

  task automatic test_protocol_error();
    int st, lat; logic [31:0] d; logic p; logic seen;
    bus_write(2'd2, 4'hF, $urandom, 1'b1, st);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.readdatavalid) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL perr_no_valid got=%b exp=0", seen); end
    bus_read(2'd2, d, lat, p);
    checks++; if (d !== model_read(2'd2)) begin failures++; $display("FAIL perr_data got=%h exp=%h", d, model_read(2'd2)); end
    bus_read(2'd3, d, lat, p);
    checks++; if (d[31] !== 1'b1 || d !== model_read(2'd3)) begin failures++; $display("FAIL perr_status got=%h exp=%h", d, model_read(2'd3)); end
    bus_write(2'd3, 4'b1000, 32'h8000_0000, 1'b0, st);
    bus_read(2'd3, d, lat, p);
    checks++; if (d[31] !== 1'b0 || d !== model_read(2'd3)) begin failures++; $display("FAIL err_clear got=%h exp=%h", d, model_read(2'd3)); end
    bus_write(2'd3, 4'b1000, 32'h8000_0000, 1'b1, st);
    bus_read(2'd3, d, lat, p);
    checks++; if (d[31] !== 1'b1 || d !== model_read(2'd3)) begin failures++; $display("FAIL err_set_wins got=%h exp=%h", d, model_read(2'd3)); end
    bus_write(2'd3, 4'b0111, 32'hFFFF_FFFF, 1'b0, st);
    bus_read(2'd3, d, lat, p);
    checks++; if (d !== model_read(2'd3)) begin failures++; $display("FAIL err_noclear_be got=%h exp=%h", d, model_read(2'd3)); end
    bus_write(2'd3, 4'b1000, 32'h8000_0000, 1'b0, st);
  endtask

  task automatic test_abandon();
    int st, lat; logic [31:0] d; logic p;
    bus.write = 1'b1; bus.address = 2'd0; bus.byteenable = 4'hF; bus.writedata = ~mreg[0];
    #1;
    checks++; if (bus.waitrequest !== 1'b1) begin failures++; $display("FAIL abandon_stall got=%b exp=1", bus.waitrequest); end
    @(posedge clk); #1;
    idle();
    @(posedge clk); #1;
    checks++; if (reg0_q !== mreg[0]) begin failures++; $display("FAIL abandon_reg0 got=%h exp=%h", reg0_q, mreg[0]); end
    bus_read(2'd3, d, lat, p);
    checks++; if (d !== model_read(2'd3)) begin failures++; $display("FAIL abandon_count got=%h exp=%h", d, model_read(2'd3)); end
    bus_write(2'd1, 4'hF, $urandom, 1'b0, st);
    checks++; if (st != 1) begin failures++; $display("FAIL abandon_ws_clear got=%0d exp=1", st); end
  endtask

  task automatic test_random();
    int st, lat; logic [31:0] d, d2; logic p;
    logic [1:0] a; logic [3:0] be;
    for (int n = 0; n < 40; n++) begin
      a  = 2'($urandom_range(0, 3));
      be = 4'($urandom);
      d  = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        bus_write(a, be, d, ($urandom_range(0, 7) == 0), st);
        checks++; if (st != 1) begin failures++; $display("FAIL rnd_wr_stalls n=%0d got=%0d exp=1", n, st); end
      end else begin
        bus_read(a, d2, lat, p);
        checks++; if (d2 !== model_read(a) || lat != 2) begin failures++; $display("FAIL rnd_rd n=%0d a=%0d got=%h/%0d exp=%h/2", n, a, d2, lat, model_read(a)); end
      end
    end
    checks++; if (reg0_q !== mreg[0]) begin failures++; $display("FAIL rnd_reg0_q got=%h exp=%h", reg0_q, mreg[0]); end
  endtask

  task automatic test_saturate();
    int st, lat; logic [31:0] d; logic p;
    force dut.status_wcount = 31'h7FFF_FFFD;
    #1;
    release dut.status_wcount;
    mwcnt = 31'h7FFF_FFFD;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) bus_write(2'($urandom_range(0, 2)), 4'($urandom), $urandom, 1'b0, st);
    bus_read(2'd3, d, lat, p);
    checks++; if (d[30:0] !== 31'h7FFF_FFFF || d !== model_read(2'd3)) begin failures++; $display("FAIL wcount_saturate got=%h exp=%h", d, model_read(2'd3)); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_rmw();
    test_byte_lanes();
    test_back_to_back_ws0();
    test_protocol_error();
    test_abandon();
    test_random();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
